// File: rtl/sdram_client_arbiter_if.sv
// Toggle req/ack channel between the client arbiter and one SDRAM controller port.
// The master toggles req to start a transfer; the controller toggles ack to finish it.
interface sdram_bus #(
   parameter int ADDR_BITS = 22
);
   logic                 req;
   logic                 ack;
   logic                 we;
   logic [ADDR_BITS-1:0] address;
   logic [15:0]          data_write;
   logic [15:0]          data_read;

   modport master (output req, we, address, data_write, input ack, data_read);
   modport slave  (input req, we, address, data_write, output ack, data_read);
endinterface

// File: rtl/sdram_client_arbiter.sv
// Round-robin arbiter multiplexing NUM_CLIENTS toggle-handshake requesters onto one
// SDRAM controller channel. One downstream transaction is outstanding at a time.
module sdram_client_arbiter #(
   parameter int NUM_CLIENTS = 4,
   parameter int ADDR_BITS   = 22
) (
   input  logic                             sdram_clk,
   input  logic                             rst,
   input  logic [NUM_CLIENTS-1:0]           cl_req,
   output logic [NUM_CLIENTS-1:0]           cl_ack,
   input  logic [NUM_CLIENTS-1:0]           cl_we,
   input  logic [NUM_CLIENTS*ADDR_BITS-1:0] cl_address,
   input  logic [NUM_CLIENTS*16-1:0]        cl_data_write,
   output logic [NUM_CLIENTS*16-1:0]        cl_data_read,
   sdram_bus.master                         mem,
   output logic                             busy,
   output logic [$clog2(NUM_CLIENTS)-1:0]   grant
);
   localparam int GW = $clog2(NUM_CLIENTS);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t                        state_q, state_d;
   logic [GW-1:0]                 rr_ptr_q, rr_ptr_d;
   logic [GW-1:0]                 grant_q, grant_d;
   logic                          busy_q, busy_d;
   logic [NUM_CLIENTS-1:0]        cl_ack_q, cl_ack_d;
   logic [NUM_CLIENTS*16-1:0]     cl_data_read_q, cl_data_read_d;
   logic                          mem_req_q, mem_req_d;
   logic                          mem_we_q, mem_we_d;
   logic [ADDR_BITS-1:0]          mem_address_q, mem_address_d;
   logic [15:0]                   mem_data_write_q, mem_data_write_d;

   logic [NUM_CLIENTS-1:0]        pending;
   logic                          found;
   logic [GW-1:0]                 pick;
   int                            idx;
   int                            pi;
   int                            gi;

   always_comb begin
      state_d          = state_q;
      rr_ptr_d         = rr_ptr_q;
      grant_d          = grant_q;
      busy_d           = busy_q;
      cl_ack_d         = cl_ack_q;
      cl_data_read_d   = cl_data_read_q;
      mem_req_d        = mem_req_q;
      mem_we_d         = mem_we_q;
      mem_address_d    = mem_address_q;
      mem_data_write_d = mem_data_write_q;
      pending          = cl_req ^ cl_ack_q;
      found            = 1'b0;
      pick             = '0;
      idx              = 0;
      pi               = 0;
      gi               = int'(grant_q);

      // Rotating scan: first pending client at or after rr_ptr, modulo NUM_CLIENTS.
      for (int k = 0; k < NUM_CLIENTS; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
         if (!found && pending[idx]) begin
            found = 1'b1;
            pick  = GW'(idx);
         end
      end
      pi = int'(pick);

      case (state_q)
         S_IDLE: begin
            // A stale ack (e.g. from a transfer abandoned by reset) is absorbed, not forwarded.
            if (mem.ack != mem_req_q) begin
               mem_req_d = mem.ack;
            end else if (found) begin
               grant_d          = pick;
               busy_d           = 1'b1;
               mem_we_d         = cl_we[pi];
               mem_address_d    = cl_address[pi*ADDR_BITS +: ADDR_BITS];
               mem_data_write_d = cl_data_write[pi*16 +: 16];
               mem_req_d        = ~mem_req_q;
               state_d          = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem.ack == mem_req_q) begin
               if (!mem_we_q) cl_data_read_d[gi*16 +: 16] = mem.data_read;
               cl_ack_d[gi] = cl_req[gi];
               rr_ptr_d     = (grant_q == GW'(NUM_CLIENTS-1)) ? '0 : grant_q + 1'b1;
               busy_d       = 1'b0;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sdram_clk) begin
      if (rst) begin
         state_q          <= S_IDLE;
         rr_ptr_q         <= '0;
         grant_q          <= '0;
         busy_q           <= 1'b0;
         cl_ack_q         <= '0;
         cl_data_read_q   <= '0;
         mem_req_q        <= mem.ack;
         mem_we_q         <= 1'b0;
         mem_address_q    <= '0;
         mem_data_write_q <= '0;
      end else begin
         state_q          <= state_d;
         rr_ptr_q         <= rr_ptr_d;
         grant_q          <= grant_d;
         busy_q           <= busy_d;
         cl_ack_q         <= cl_ack_d;
         cl_data_read_q   <= cl_data_read_d;
         mem_req_q        <= mem_req_d;
         mem_we_q         <= mem_we_d;
         mem_address_q    <= mem_address_d;
         mem_data_write_q <= mem_data_write_d;
      end
   end

   assign cl_ack         = cl_ack_q;
   assign cl_data_read   = cl_data_read_q;
   assign busy           = busy_q;
   assign grant          = grant_q;
   assign mem.req        = mem_req_q;
   assign mem.we         = mem_we_q;
   assign mem.address    = mem_address_q;
   assign mem.data_write = mem_data_write_q;
endmodule
